varredor_x: RTL and testbench

//  Upstream sequencer for quadratic_eq: sweeps x from x_ini to x_fim in steps of passo.
//  For each point it pulses inicio_eq, waits for pronto_eq and captures resultado_eq.

---
 rtl/varredor_x_if.sv | 24 ++
 rtl/varredor_x.sv | 185 ++++++++++++++++++
 tb/tb_varredor_x.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/varredor_x_if.sv
// rtl/varredor_x_if.sv - quadratic_eq handshake and (x, y) output stream bundle
interface varredor_x_if;
    // sequencer -> quadratic_eq
    logic [7:0]  x_eq;
    logic        inicio_eq;
    // quadratic_eq -> sequencer
    logic        pronto_eq;
    logic [15:0] resultado_eq;
    // output pair stream
    logic        saida_valida;
    logic        saida_pronta;
    logic [7:0]  saida_x;
    logic [15:0] saida_y;

    modport master (
        output x_eq, inicio_eq, saida_valida, saida_x, saida_y,
        input  pronto_eq, resultado_eq, saida_pronta
    );

    modport slave (
        input  x_eq, inicio_eq, saida_valida, saida_x, saida_y,
        output pronto_eq, resultado_eq, saida_pronta
    );
endinterface

// File: rtl/varredor_x.sv
// rtl/varredor_x.sv - x sweep sequencer for quadratic_eq; optional running minimum under VARREDOR_MINIMO_EN
module varredor_x #(
    parameter int TIMEOUT = 64,
    parameter int CONT_W  = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        partida,
    input  logic [7:0]  x_ini,
    input  logic [7:0]  x_fim,
    input  logic [7:0]  passo,
    output logic        ocupado,
    output logic        fim,
    output logic        erro,
    varredor_x_if.master bus
`ifdef VARREDOR_MINIMO_EN
    ,
    output logic [15:0] y_min,
    output logic [7:0]  x_min
`endif
);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        DISPARA = 3'd1,
        ESPERA  = 3'd2,
        EMITE   = 3'd3,
        FIM     = 3'd4
    } estado_t;

    estado_t           r_state;
    estado_t           w_next;

    logic [7:0]        r_x_fim;
    logic [7:0]        r_passo;
    logic [7:0]        r_x_eq;
    logic [CONT_W-1:0] r_cnt;
    logic              r_erro;
    logic              r_saida_valida;
    logic [7:0]        r_saida_x;
    logic [15:0]       r_saida_y;

    logic              w_aceita;
    logic              w_captura;
    logic              w_handshake;
    logic              w_avanca;
    logic              w_timeout;
    logic [7:0]        w_passo_ef;
    logic [8:0]        w_soma;

    // A zero step would never terminate, so it behaves as a step of one.
    assign w_passo_ef = (r_passo == 8'd0) ? 8'd1 : r_passo;
    // Ninth bit catches a step that wraps past 255.
    assign w_soma     = {1'b0, r_x_eq} + {1'b0, w_passo_ef};

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= OCIOSO;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and datapath strobes.
    always_comb begin
        w_next      = r_state;
        w_aceita    = 1'b0;
        w_captura   = 1'b0;
        w_handshake = 1'b0;
        w_avanca    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            OCIOSO: begin
                if (partida) begin
                    w_aceita = 1'b1;
                    w_next   = (x_ini > x_fim) ? FIM : DISPARA;
                end
            end
            DISPARA: begin
                w_next = ESPERA;
            end
            ESPERA: begin
                // First ESPERA cycle (counter still 0) ignores a stale pronto_eq.
                if ((r_cnt != '0) && bus.pronto_eq) begin
                    w_captura = 1'b1;
                    w_next    = EMITE;
                end else if (r_cnt == CONT_W'(TIMEOUT - 1)) begin
                    w_timeout = 1'b1;
                    w_next    = FIM;
                end
            end
            EMITE: begin
                if (r_saida_valida && bus.saida_pronta) begin
                    w_handshake = 1'b1;
                    if (w_soma > {1'b0, r_x_fim}) begin
                        w_next = FIM;
                    end else begin
                        w_avanca = 1'b1;
                        w_next   = DISPARA;
                    end
                end
            end
            FIM: begin
                w_next = OCIOSO;
            end
            default: begin
                w_next = OCIOSO;
            end
        endcase
    end

    // Operand latches, wait counter, error flag and the one-entry output buffer.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_x_fim        <= 8'd0;
            r_passo        <= 8'd0;
            r_x_eq         <= 8'd0;
            r_cnt          <= '0;
            r_erro         <= 1'b0;
            r_saida_valida <= 1'b0;
            r_saida_x      <= 8'd0;
            r_saida_y      <= 16'd0;
        end else begin
            if (w_aceita) begin
                r_x_fim <= x_fim;
                r_passo <= passo;
                r_erro  <= 1'b0;
                if (x_ini <= x_fim) begin
                    r_x_eq <= x_ini;
                end
            end
            if (r_state == DISPARA) begin
                r_cnt <= '0;
            end else if (r_state == ESPERA) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_erro <= 1'b1;
            end
            if (w_captura) begin
                r_saida_x      <= r_x_eq;
                r_saida_y      <= bus.resultado_eq;
                r_saida_valida <= 1'b1;
            end else if (w_handshake) begin
                r_saida_valida <= 1'b0;
            end
            if (w_avanca) begin
                r_x_eq <= w_soma[7:0];
            end
        end
    end

`ifdef VARREDOR_MINIMO_EN
    logic [15:0] r_y_min;
    logic [7:0]  r_x_min;

    // Running minimum over the sweep; strict compare keeps the earliest x on ties.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_y_min <= 16'd0;
            r_x_min <= 8'd0;
        end else if (w_aceita) begin
            r_y_min <= 16'hFFFF;
            r_x_min <= 8'd0;
        end else if (w_captura && (bus.resultado_eq < r_y_min)) begin
            r_y_min <= bus.resultado_eq;
            r_x_min <= r_x_eq;
        end
    end

    assign y_min = r_y_min;
    assign x_min = r_x_min;
`endif

    assign ocupado          = (r_state != OCIOSO);
    assign fim              = (r_state == FIM);
    assign erro             = r_erro;
    assign bus.x_eq         = r_x_eq;
    assign bus.inicio_eq    = (r_state == DISPARA);
    assign bus.saida_valida = r_saida_valida;
    assign bus.saida_x      = r_saida_x;
    assign bus.saida_y      = r_saida_y;

endmodule

// File: tb/tb_varredor_x.sv
// tb/tb_varredor_x.sv - directed bench for varredor_x with a behavioural quadratic_eq (a=1, b=0, c=eq_c)
module tb_varredor_x;

    logic        clock;
    logic        reset;
    logic        partida;
    logic [7:0]  x_ini;
    logic [7:0]  x_fim;
    logic [7:0]  passo;
    logic        ocupado;
    logic        fim;
    logic        erro;
`ifdef VARREDOR_MINIMO_EN
    logic [15:0] y_min;
    logic [7:0]  x_min;
`endif

    varredor_x_if bus ();

    varredor_x #(.TIMEOUT(64), .CONT_W(8)) dut (
        .clock   (clock),
        .reset   (reset),
        .partida (partida),
        .x_ini   (x_ini),
        .x_fim   (x_fim),
        .passo   (passo),
        .ocupado (ocupado),
        .fim     (fim),
        .erro    (erro),
        .bus     (bus.master)
`ifdef VARREDOR_MINIMO_EN
        ,
        .y_min   (y_min),
        .x_min   (x_min)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // quadratic_eq model: result x*x + eq_c, pronto_eq two cycles after inicio_eq.
    logic        eq_stuck;
    logic [15:0] eq_c;
    logic [7:0]  m_x;
    logic [1:0]  m_cnt;

    always @(posedge clock) begin
        if (!reset) begin
            m_cnt          <= 2'd0;
            m_x            <= 8'd0;
            bus.pronto_eq  <= 1'b0;
            bus.resultado_eq <= 16'd0;
        end else begin
            bus.pronto_eq <= 1'b0;
            if (bus.inicio_eq) begin
                m_x   <= bus.x_eq;
                m_cnt <= 2'd2;
            end else if (m_cnt != 2'd0) begin
                m_cnt <= m_cnt - 2'd1;
                if (m_cnt == 2'd1 && !eq_stuck) begin
                    bus.pronto_eq    <= 1'b1;
                    bus.resultado_eq <= ({8'd0, m_x} * {8'd0, m_x}) + eq_c;
                end
            end
        end
    end

    int n_chk;
    int n_err;
    int n_pairs;
    int n_ini;
    int n_fim;
    int fim_at;
    int ini_at;
    int saw_valid;
    logic erro_at_fim;
    logic [7:0]  px [16];
    logic [15:0] py [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [7:0] xi, input logic [7:0] xf, input logic [7:0] p);
        @(negedge clock);
        x_ini   = xi;
        x_fim   = xf;
        passo   = p;
        partida = 1'b1;
        @(posedge clock);
        #1;
        partida = 1'b0;
    endtask

    task automatic collect(input int budget);
        n_pairs   = 0;
        n_ini     = 0;
        n_fim     = 0;
        fim_at    = -1;
        ini_at    = -1;
        saw_valid = 0;
        erro_at_fim = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            if (bus.saida_valida) saw_valid = 1;
            if (bus.inicio_eq) begin
                n_ini++;
                if (ini_at < 0) ini_at = k;
            end
            if (bus.saida_valida && bus.saida_pronta && n_pairs < 16) begin
                px[n_pairs] = bus.saida_x;
                py[n_pairs] = bus.saida_y;
                n_pairs++;
            end
            if (fim) begin
                n_fim++;
                fim_at = k;
                erro_at_fim = erro;
                break;
            end
        end
        chk("fim_reached", (fim_at >= 0) ? 32'd1 : 32'd0, 32'd1);
        @(negedge clock);
        chk("fim_one_cycle", {31'd0, fim}, 32'd0);
        chk("idle_after_fim", {31'd0, ocupado}, 32'd0);
    endtask

    logic [7:0]  hold_x;
    logic [15:0] hold_y;
    int          stable_bad;
    int          ini_bad;
    int          seen;

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b0;
        partida = 1'b0;
        x_ini = 8'd0;
        x_fim = 8'd0;
        passo = 8'd0;
        eq_stuck = 1'b0;
        eq_c = 16'd0;
        bus.saida_pronta = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_ocupado", {31'd0, ocupado}, 32'd0);
        chk("rst_fim", {31'd0, fim}, 32'd0);
        chk("rst_erro", {31'd0, erro}, 32'd0);
        chk("rst_valida", {31'd0, bus.saida_valida}, 32'd0);
        chk("rst_inicio", {31'd0, bus.inicio_eq}, 32'd0);
        reset = 1'b1;

        // 1) basic sweep 0..3 step 1
        start(8'd0, 8'd3, 8'd1);
        collect(200);
        chk("t1_pairs", n_pairs, 32'd4);
        chk("t1_x0", {24'd0, px[0]}, 32'd0);
        chk("t1_y0", {16'd0, py[0]}, 32'd0);
        chk("t1_x1", {24'd0, px[1]}, 32'd1);
        chk("t1_y1", {16'd0, py[1]}, 32'd1);
        chk("t1_y2", {16'd0, py[2]}, 32'd4);
        chk("t1_x3", {24'd0, px[3]}, 32'd3);
        chk("t1_y3", {16'd0, py[3]}, 32'd9);
        chk("t1_fims", n_fim, 32'd1);
        chk("t1_erro", {31'd0, erro_at_fim}, 32'd0);

        // 2) no wrap past 255
        start(8'd250, 8'd255, 8'd4);
        collect(200);
        chk("t2_pairs", n_pairs, 32'd2);
        chk("t2_x0", {24'd0, px[0]}, 32'd250);
        chk("t2_y0", {16'd0, py[0]}, 32'd62500);
        chk("t2_x1", {24'd0, px[1]}, 32'd254);
        chk("t2_y1", {16'd0, py[1]}, 32'd64516);

        // 3) empty range goes straight to FIM
        start(8'd5, 8'd2, 8'd1);
        collect(20);
        chk("t3_fim_at", fim_at, 32'd0);
        chk("t3_valid", saw_valid, 32'd0);
        chk("t3_inicio", n_ini, 32'd0);

        // zero step behaves as step one
        start(8'd7, 8'd9, 8'd0);
        collect(200);
        chk("p0_pairs", n_pairs, 32'd3);
        chk("p0_x2", {24'd0, px[2]}, 32'd9);
        chk("p0_y2", {16'd0, py[2]}, 32'd81);

        // 4) consumer stall holds the buffer and blocks the next point
        bus.saida_pronta = 1'b0;
        start(8'd0, 8'd3, 8'd1);
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clock);
            if (bus.saida_valida) seen = 1;
        end
        chk("t4_valid_seen", seen, 32'd1);
        hold_x = bus.saida_x;
        hold_y = bus.saida_y;
        chk("t4_hold_x", {24'd0, hold_x}, 32'd0);
        stable_bad = 0;
        ini_bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (!bus.saida_valida || bus.saida_x !== hold_x || bus.saida_y !== hold_y) stable_bad++;
            if (bus.inicio_eq) ini_bad++;
        end
        chk("t4_stable", stable_bad, 32'd0);
        chk("t4_no_inicio", ini_bad, 32'd0);
        bus.saida_pronta = 1'b1;
        collect(200);
        chk("t4_rest_pairs", n_pairs, 32'd3);
        chk("t4_last_y", {16'd0, py[2]}, 32'd9);

        // 5) timeout after 64 ESPERA cycles
        eq_stuck = 1'b1;
        start(8'd0, 8'd3, 8'd1);
        collect(300);
        chk("t5_erro", {31'd0, erro_at_fim}, 32'd1);
        chk("t5_pairs", n_pairs, 32'd0);
        chk("t5_ini", n_ini, 32'd1);
        chk("t5_latency", fim_at - ini_at, 32'd65);
        chk("t5_erro_sticky", {31'd0, erro}, 32'd1);
        eq_stuck = 1'b0;
        start(8'd1, 8'd1, 8'd1);
        @(negedge clock);
        chk("t5_erro_clear", {31'd0, erro}, 32'd0);
        collect(200);
        chk("t5_after_pairs", n_pairs, 32'd1);
        chk("t5_after_y", {16'd0, py[0]}, 32'd1);

        // 6) reset mid-ESPERA after one pair was emitted
        start(8'd2, 8'd3, 8'd1);
        seen = 0;
        for (int k = 0; k < 50 && seen < 2; k++) begin
            @(negedge clock);
            if (bus.inicio_eq) seen++;
        end
        chk("t6_second_inicio", seen, 32'd2);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        chk("t6_ocupado", {31'd0, ocupado}, 32'd0);
        chk("t6_fim", {31'd0, fim}, 32'd0);
        chk("t6_erro", {31'd0, erro}, 32'd0);
        chk("t6_x_eq", {24'd0, bus.x_eq}, 32'd0);
        chk("t6_saida_x", {24'd0, bus.saida_x}, 32'd0);
        chk("t6_saida_y", {16'd0, bus.saida_y}, 32'd0);
        chk("t6_valida", {31'd0, bus.saida_valida}, 32'd0);
        saw_valid = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (bus.saida_valida || ocupado) saw_valid = 1;
        end
        chk("t6_quiet", saw_valid, 32'd0);

`ifdef VARREDOR_MINIMO_EN
        chk("min_rst_y", {16'd0, y_min}, 32'd0);
        eq_c = 16'd5;
        start(8'd0, 8'd3, 8'd1);
        collect(200);
        chk("min_y", {16'd0, y_min}, 32'd5);
        chk("min_x", {24'd0, x_min}, 32'd0);
        start(8'd3, 8'd1, 8'd1);
        collect(20);
        chk("min_empty_y", {16'd0, y_min}, 32'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
